// File: rtl/ssd_display_driver_if.sv
// Bundle of the display driver's data and display-pin signals.
// The master side (CPU top level or bench) drives the value and mode; the
// slave side (the driver) returns the multiplexed display lines and busy.
interface ssd_display_driver_if;
  logic [12:0] value;
  logic        hex_mode;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        busy;

  modport master (
    output value,
    output hex_mode,
    input  anode,
    input  seg,
    input  busy
  );

  modport slave (
    input  value,
    input  hex_mode,
    output anode,
    output seg,
    output busy
  );
endinterface

// File: rtl/ssd_display_driver.sv
// Four-digit common-anode seven-segment driver for the 13-bit SSD debug word.
// A double-dabble FSM converts the value to BCD one shift per clock, and a
// refresh divider steps a digit index that selects which digit is lit.
// Hex mode bypasses conversion and shows the raw nibbles of the live value.
module ssd_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input logic clk,
  input logic rst,
  ssd_display_driver_if.slave bus
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t            state_r;
  logic [12:0]       cap_r;
  logic [28:0]       shift_r;
  logic [3:0]        iter_r;
  logic [15:0]       bcd_r;
  logic              busy_r;
  logic [DIV_W-1:0]  div_r;
  logic [1:0]        idx_r;
  logic [3:0]        anode_r;
  logic [6:0]        seg_r;

  logic [28:0]       adj_s;
  logic [28:0]       shift_nxt_s;
  logic [3:0][3:0]   digits_s;
  logic [3:0]        blank_s;
  logic [3:0]        cur_digit_s;
  logic              cur_blank_s;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  function automatic logic [28:0] bcd_adjust(input logic [28:0] s);
    logic [28:0] r;
    r = s;
    for (int k = 0; k < 4; k++) begin
      if (r[13+4*k +: 4] >= 4'd5) begin
        r[13+4*k +: 4] = r[13+4*k +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex digit.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'h0:    p = 7'b1000000;
      4'h1:    p = 7'b1111001;
      4'h2:    p = 7'b0100100;
      4'h3:    p = 7'b0110000;
      4'h4:    p = 7'b0011001;
      4'h5:    p = 7'b0010010;
      4'h6:    p = 7'b0000010;
      4'h7:    p = 7'b1111000;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0010000;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b0000011;
      4'hC:    p = 7'b1000110;
      4'hD:    p = 7'b0100001;
      4'hE:    p = 7'b0000110;
      4'hF:    p = 7'b0001110;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Next double-dabble shift register contents (adjust, then shift left).
  always_comb begin
    adj_s       = bcd_adjust(shift_r);
    shift_nxt_s = {adj_s[27:0], 1'b0};
  end

  // Digit source for the selected mode, leading-zero blanking and the current digit.
  always_comb begin
    if (bus.hex_mode) begin
      digits_s = {{3'b000, bus.value[12]}, bus.value[11:8], bus.value[7:4], bus.value[3:0]};
    end else begin
      digits_s = bcd_r;
    end
    blank_s[0] = 1'b0;
    blank_s[3] = BLANK_LZ && (digits_s[3] == 4'd0);
    blank_s[2] = blank_s[3] && (digits_s[2] == 4'd0);
    blank_s[1] = blank_s[2] && (digits_s[1] == 4'd0);
    cur_digit_s = digits_s[idx_r];
    cur_blank_s = blank_s[idx_r];
  end

  // Conversion FSM: capture a changed value, then 13 adjust-and-shift steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cap_r   <= 13'd0;
      shift_r <= 29'd0;
      iter_r  <= 4'd0;
      bcd_r   <= 16'd0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.value != cap_r) begin
            cap_r   <= bus.value;
            shift_r <= {16'd0, bus.value};
            iter_r  <= 4'd0;
            state_r <= CONV;
            busy_r  <= 1'b1;
          end
        end
        CONV: begin
          shift_r <= shift_nxt_s;
          if (iter_r == 4'd12) begin
            bcd_r   <= shift_nxt_s[28:13];
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            iter_r <= iter_r + 4'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Refresh divider and digit index; the index advances at the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r <= '0;
      idx_r <= 2'd0;
    end else if (div_r == DIV_LAST) begin
      div_r <= '0;
      idx_r <= idx_r + 2'd1;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Registered display lines for the digit selected by the index.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode_r <= 4'b1110;
      seg_r   <= 7'b1000000;
    end else if (cur_blank_s) begin
      anode_r <= 4'b1111;
      seg_r   <= 7'b1111111;
    end else begin
      anode_r <= ~(4'b0001 << idx_r);
      seg_r   <= seg_of(cur_digit_s);
    end
  end

  assign bus.anode = anode_r;
  assign bus.seg   = seg_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_ssd_display_driver.sv
// Directed bench for ssd_display_driver with a short refresh divider.
module tb_ssd_display_driver;

  logic clk;
  logic rst;
  ssd_display_driver_if bus ();

  ssd_display_driver #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] frame_seg  [4];
  bit         frame_seen [4];
  bit         frame_multi;
  bit         wait_to;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S7 = 7'b1111000, S8 = 7'b0000000, S9 = 7'b0010000,
                         SA = 7'b0001000, SB = 7'b0000011, SC = 7'b1000110,
                         SF = 7'b0001110;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Record which anodes go low over more than one frame and the segs shown.
  task automatic collect_frame();
    int lows;
    for (int k = 0; k < 4; k++) begin
      frame_seen[k] = 1'b0;
      frame_seg[k]  = 7'b1111111;
    end
    frame_multi = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      lows = 0;
      for (int k = 0; k < 4; k++) begin
        if (bus.anode[k] === 1'b0) begin
          lows++;
          frame_seen[k] = 1'b1;
          frame_seg[k]  = bus.seg;
        end
      end
      if (lows > 1) frame_multi = 1'b1;
    end
  endtask

  // Step until busy is sampled low, with a cycle budget.
  task automatic wait_idle();
    int c;
    c = 0;
    step();
    while (bus.busy === 1'b1 && c < 100) begin
      step();
      c++;
    end
    wait_to = (bus.busy !== 1'b0);
  endtask

  task automatic test_reset();
    bit saw_busy;
    bit bad_an;
    rst = 1'b1;
    bus.value = 13'd0;
    bus.hex_mode = 1'b0;
    step();
    step();
    n_cmp++; if (bus.anode !== 4'b1110) begin n_err++; $display("FAIL reset_anode got=%b exp=1110", bus.anode); end
    n_cmp++; if (bus.seg !== S0) begin n_err++; $display("FAIL reset_seg got=%b exp=%b", bus.seg, S0); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    saw_busy = 1'b0;
    bad_an = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.busy !== 1'b0) saw_busy = 1'b1;
      if (bus.anode !== 4'b1110 && bus.anode !== 4'b1111) bad_an = 1'b1;
    end
    n_cmp++; if (saw_busy !== 1'b0) begin n_err++; $display("FAIL reset_hold_busy got=1 exp=0"); end
    n_cmp++; if (bad_an !== 1'b0) begin n_err++; $display("FAIL reset_hold_anode got=%b exp=1110/1111", bus.anode); end
  endtask

  task automatic test_decimal();
    logic [6:0] exp_seg [4];
    int cnt;
    logic first;
    exp_seg = '{S4, S3, S2, S1};
    bus.value = 13'd1234;
    step();
    first = bus.busy;
    cnt = (bus.busy === 1'b1) ? 1 : 0;
    for (int c = 0; c < 40 && bus.busy === 1'b1; c++) begin
      step();
      if (bus.busy === 1'b1) cnt++;
    end
    n_cmp++; if (first !== 1'b1) begin n_err++; $display("FAIL dec_busy_start got=%b exp=1", first); end
    n_cmp++; if (cnt !== 13) begin n_err++; $display("FAIL dec_busy_len got=%0d exp=13", cnt); end
    collect_frame();
    n_cmp++; if (frame_multi !== 1'b0) begin n_err++; $display("FAIL dec_one_anode got=multi exp=single"); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (frame_seen[k] !== 1'b1 || frame_seg[k] !== exp_seg[k]) begin
        n_err++; $display("FAIL dec_digit%0d got=%b seen=%0d exp=%b", k, frame_seg[k], frame_seen[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_full_scale();
    logic [6:0] exp_seg [4];
    exp_seg = '{S1, S9, S1, S8};
    bus.value = 13'd8191;
    wait_idle();
    n_cmp++; if (wait_to !== 1'b0) begin n_err++; $display("FAIL full_timeout got=busy exp=idle"); end
    collect_frame();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (frame_seen[k] !== 1'b1 || frame_seg[k] !== exp_seg[k]) begin
        n_err++; $display("FAIL full_digit%0d got=%b seen=%0d exp=%b", k, frame_seg[k], frame_seen[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_blank();
    bus.value = 13'd7;
    wait_idle();
    n_cmp++; if (wait_to !== 1'b0) begin n_err++; $display("FAIL blank_timeout got=busy exp=idle"); end
    collect_frame();
    n_cmp++; if (frame_seen[0] !== 1'b1 || frame_seg[0] !== S7) begin
      n_err++; $display("FAIL blank_digit0 got=%b seen=%0d exp=%b", frame_seg[0], frame_seen[0], S7);
    end
    n_cmp++; if ({frame_seen[3], frame_seen[2], frame_seen[1]} !== 3'b000) begin
      n_err++; $display("FAIL blank_upper got_lit=%b%b%b exp=000", frame_seen[3], frame_seen[2], frame_seen[1]);
    end
  endtask

  task automatic test_change_busy();
    logic [59:0] got_b;
    logic [59:0] exp_b;
    logic [6:0]  exp100 [3];
    logic [6:0]  exp_seg [4];
    int obs;
    bit bad100;
    exp100  = '{S0, S0, S1};
    exp_seg = '{S5, S9, S0, S4};
    obs = 0;
    bad100 = 1'b0;
    bus.value = 13'd100;
    for (int i = 0; i < 60; i++) begin
      step();
      got_b[i] = bus.busy;
      exp_b[i] = (i <= 12) || (i >= 14 && i <= 26);
      if (i >= 14 && i <= 26 && bus.anode !== 4'b1111) begin
        obs++;
        if (bus.anode[3] === 1'b0) bad100 = 1'b1;
        for (int k = 0; k < 3; k++) begin
          if (bus.anode[k] === 1'b0 && bus.seg !== exp100[k]) bad100 = 1'b1;
        end
      end
      if (i == 4) bus.value = 13'd4095;
    end
    n_cmp++; if (got_b !== exp_b) begin n_err++; $display("FAIL chg_busy_pattern got=%h exp=%h", got_b, exp_b); end
    n_cmp++; if (obs == 0 || bad100) begin n_err++; $display("FAIL chg_shows_100 got_obs=%0d bad=%0d exp=digits 1,0,0", obs, bad100); end
    collect_frame();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (frame_seen[k] !== 1'b1 || frame_seg[k] !== exp_seg[k]) begin
        n_err++; $display("FAIL chg_digit%0d got=%b seen=%0d exp=%b", k, frame_seg[k], frame_seen[k], exp_seg[k]);
      end
    end
  endtask

  task automatic test_hex();
    logic [6:0] exp_seg [4];
    bit saw_busy;
    exp_seg = '{SC, SB, SA, S1};
    bus.value = 13'h1ABC;
    wait_idle();
    n_cmp++; if (wait_to !== 1'b0) begin n_err++; $display("FAIL hex_timeout got=busy exp=idle"); end
    bus.hex_mode = 1'b1;
    saw_busy = 1'b0;
    step();
    if (bus.busy !== 1'b0) saw_busy = 1'b1;
    collect_frame();
    if (bus.busy !== 1'b0) saw_busy = 1'b1;
    n_cmp++; if (saw_busy !== 1'b0) begin n_err++; $display("FAIL hex_no_busy got=1 exp=0"); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (frame_seen[k] !== 1'b1 || frame_seg[k] !== exp_seg[k]) begin
        n_err++; $display("FAIL hex_digit%0d got=%b seen=%0d exp=%b", k, frame_seg[k], frame_seen[k], exp_seg[k]);
      end
    end
    bus.value = 13'h00F;
    step();
    collect_frame();
    n_cmp++; if (frame_seen[0] !== 1'b1 || frame_seg[0] !== SF) begin
      n_err++; $display("FAIL hex_blank_digit0 got=%b seen=%0d exp=%b", frame_seg[0], frame_seen[0], SF);
    end
    n_cmp++; if ({frame_seen[3], frame_seen[2], frame_seen[1]} !== 3'b000) begin
      n_err++; $display("FAIL hex_blank_upper got_lit=%b%b%b exp=000", frame_seen[3], frame_seen[2], frame_seen[1]);
    end
    bus.hex_mode = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp_seg [4];
    bit bad0;
    exp_seg = '{S0, S0, S0, S5};
    bus.value = 13'd5000;
    for (int c = 0; c < 6; c++) step();
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rmid_busy_before got=%b exp=1", bus.busy); end
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (bus.anode !== 4'b1110 || bus.seg !== S0 || bus.busy !== 1'b0) begin
      n_err++; $display("FAIL rmid_reset_out got=%b/%b/%b exp=1110/%b/0", bus.anode, bus.seg, bus.busy, S0);
    end
    rst = 1'b0;
    step();
    n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL rmid_restart got=%b exp=1", bus.busy); end
    bad0 = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.anode !== 4'b1110 && bus.anode !== 4'b1111) bad0 = 1'b1;
      if (bus.anode === 4'b1110 && bus.seg !== S0) bad0 = 1'b1;
    end
    n_cmp++; if (bad0 !== 1'b0) begin n_err++; $display("FAIL rmid_bcd_cleared got=%b/%b exp=only digit0 '0'", bus.anode, bus.seg); end
    wait_idle();
    n_cmp++; if (wait_to !== 1'b0) begin n_err++; $display("FAIL rmid_timeout got=busy exp=idle"); end
    collect_frame();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (frame_seen[k] !== 1'b1 || frame_seg[k] !== exp_seg[k]) begin
        n_err++; $display("FAIL rmid_digit%0d got=%b seen=%0d exp=%b", k, frame_seg[k], frame_seen[k], exp_seg[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.value = 13'd0;
    bus.hex_mode = 1'b0;
    test_reset();
    test_decimal();
    test_full_scale();
    test_blank();
    test_change_busy();
    test_hex();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
